// File: rtl/fp_norm_round.sv
// Post-add normalize/round/pack stage of the single-precision FP adder.
// Normalizes one bit per cycle, rounds to nearest-even, packs with IEEE flags.
module fp_norm_round #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  localparam int unsigned MW    = FRAC_W + 5,
  localparam int unsigned EW    = EXP_W + 2,
  localparam int unsigned RW    = 1 + EXP_W + FRAC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_sign,
  input  logic signed [EW-1:0] in_exp,
  input  logic [MW-1:0]        in_mant,
  output logic [RW-1:0]        result,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StPack} state_e;

  localparam logic signed [EW-1:0] ExpOne = EW'(1);
  localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [MW-1:0]        mant_q, mant_d;
  logic [RW-1:0]        result_q, result_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 inx_q, inx_d;

  // Round-to-nearest-even increment on the {carry, hidden, frac} field.
  logic          round_up;
  logic [MW-4:0] round_sum;
  assign round_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign round_sum = mant_q[MW-1:3] + (MW-3)'(round_up);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mant_q == '0) begin
          state_d = StPack;
        end else if (mant_q[MW-1]) begin
          // Carry out: shift right once, folding the dropped bit into sticky.
          mant_d  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + ExpOne;
          state_d = StRound;
        end else if (!mant_q[MW-2] && (exp_q > ExpOne)) begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - ExpOne;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        inx_d = |mant_q[2:0];
        if (round_sum[MW-4]) begin
          mant_d = {1'b0, round_sum, 2'b00};
          exp_d  = exp_q + ExpOne;
        end else begin
          mant_d = {round_sum, mant_q[2:0]};
        end
        state_d = StPack;
      end
      StPack: begin
        if (mant_q == '0) begin
          result_d = '0;
        end else if (exp_q >= ExpMax) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if ((exp_q < ExpOne) || !mant_q[MW-2]) begin
          // No subnormal support: flush to signed zero.
          result_d = {sign_q, {(RW-1){1'b0}}};
          unf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[MW-3:3]};
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed self-checking bench for fp_norm_round: latency, rounding, flags, reset and handshake.
module tb_fp_norm_round;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int n_cmp = 0;
  int n_err = 0;

  fp_norm_round dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .underflow(underflow),
    .inexact  (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Latency counts the start-sample edge as cycle 1; flags are {overflow, underflow, inexact}.
  task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                        input logic [27:0] m, input logic [31:0] res, input int lat,
                        input logic [2:0] flg);
    int cnt;
    @(negedge clk);
    in_sign = s;
    in_exp  = e;
    in_mant = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 1;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, " latency"}, 32'(cnt), 32'(lat));
    chk({tag, " result"}, result, res);
    chk({tag, " flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, flg});
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    reset   = 1'b1;
    start   = 1'b0;
    in_sign = 1'b0;
    in_exp  = '0;
    in_mant = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", result, 32'h0);
    chk("reset ctl", {28'd0, done, busy, overflow, underflow}, 32'd0);
    chk("reset inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("t1_carry", 1'b0, 10'd127, 28'h8000000, 32'h40000000, 4, 3'b000);
    run_op("t2_shift23", 1'b0, 10'd127, 28'h0000008, 32'h34000000, 27, 3'b000);
    run_op("t3_tie_even", 1'b0, 10'd127, 28'h4000004, 32'h3F800000, 4, 3'b001);
    run_op("t3_tie_odd", 1'b0, 10'd127, 28'h400000C, 32'h3F800002, 4, 3'b001);
    run_op("t4_rnd_carry", 1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 4, 3'b001);
    run_op("t5_ovf", 1'b0, 10'd254, 28'h8000000, 32'h7F800000, 4, 3'b100);
    run_op("t5_zero", 1'b1, 10'd127, 28'h0000000, 32'h00000000, 3, 3'b000);
    run_op("t5_unf", 1'b0, 10'd0, 28'h4000000, 32'h00000000, 4, 3'b011);
    run_op("neg_one", 1'b1, 10'd127, 28'h4000000, 32'hBF800000, 4, 3'b000);
    run_op("sticky_fold", 1'b0, 10'd127, 28'h8000006, 32'h40000000, 4, 3'b001);
    run_op("carry_round", 1'b0, 10'd127, 28'h800000C, 32'h40000001, 4, 3'b001);
    run_op("min_normal", 1'b0, 10'd3, 28'h1000000, 32'h00800000, 6, 3'b000);
    run_op("shift_stop_unf", 1'b1, 10'd2, 28'h1000000, 32'h80000000, 5, 3'b011);
    run_op("neg_exp_in", 1'b0, 10'h3FB, 28'h4000000, 32'h00000000, 4, 3'b011);
    run_op("big_exp_in", 1'b1, 10'd300, 28'h4000000, 32'hFF800000, 4, 3'b100);

    // Reset in the middle of a long normalize aborts without done.
    @(negedge clk);
    in_sign = 1'b0;
    in_exp  = 10'd127;
    in_mant = 28'h0000008;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b1;
    in_mant = 28'h4000000;
    @(posedge clk);
    #1;
    chk("reset_vs_start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;

    // A start arriving while busy must not disturb the running operation.
    @(negedge clk);
    in_sign = 1'b0;
    in_exp  = 10'd127;
    in_mant = 28'h8000000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    cnt = 1;
    @(negedge clk);
    in_sign = 1'b1;
    in_exp  = 10'd5;
    in_mant = 28'h0000000;
    @(posedge clk);
    #1;
    cnt++;
    start = 1'b0;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("busy_start latency", 32'(cnt), 32'd4);
    chk("busy_start result", result, 32'h40000000);

    // Output holds while done stays high.
    repeat (3) @(posedge clk);
    #1;
    chk("hold done", {31'd0, done}, 32'd1);
    chk("hold result", result, 32'h40000000);
    chk("hold busy", {31'd0, busy}, 32'd0);

    // Start with done=1 is accepted and done drops next cycle.
    @(negedge clk);
    in_sign = 1'b0;
    in_exp  = 10'd127;
    in_mant = 28'h4000000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart done", {31'd0, done}, 32'd0);
    chk("restart busy", {31'd0, busy}, 32'd1);
    cnt = 1;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("restart result", result, 32'h3F800000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
